// File: rtl/serial_cmp_ctrl.sv
// Bit-serial compare controller: walks an operand pair MSB-first through one XOR slice and
// accumulates mismatch flag, first-mismatch index and Hamming distance.
// Optional: define SERIAL_CMP_EARLY_EXIT_EN to stop at the first differing bit.
module serial_cmp_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH),
    parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [0:WIDTH-1]  a_i,
    input  logic [0:WIDTH-1]  b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              diff_o,
    output logic [IDXW-1:0]   first_idx_o,
    output logic [CNTW-1:0]   hamming_o
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [IDXW-1:0] LastIdx = IDXW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [0:WIDTH-1]  a_q, a_d;
    logic [0:WIDTH-1]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              diff_q, diff_d;
    logic [IDXW-1:0]   first_idx_q, first_idx_d;
    logic [CNTW-1:0]   hamming_q, hamming_d;
    logic              x;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        diff_d      = diff_q;
        first_idx_d = first_idx_q;
        hamming_d   = hamming_q;
        x           = a_q[idx_q] ^ b_q[idx_q];

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d         = a_i;
                    b_d         = b_i;
                    idx_d       = '0;
                    diff_d      = 1'b0;
                    first_idx_d = '0;
                    hamming_d   = '0;
                    state_d     = StScan;
                end
            end
            StScan: begin
                if (x) begin
                    hamming_d = hamming_q + CNTW'(1);
                    if (!diff_q) begin
                        first_idx_d = idx_q;
                        diff_d      = 1'b1;
                    end
                end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (x || (idx_q == LastIdx)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
`else
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
`endif
            end
            StDone: begin
                // Start is ignored here; the requester must re-assert it in idle.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            diff_q      <= 1'b0;
            first_idx_q <= '0;
            hamming_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            first_idx_q <= first_idx_d;
            hamming_q   <= hamming_d;
        end
    end

    assign busy_o      = (state_q == StScan);
    assign done_o      = (state_q == StDone);
    assign diff_o      = diff_q;
    assign first_idx_o = first_idx_q;
    assign hamming_o   = hamming_q;

endmodule
